rosc101_sel_chain_lvt_stress: RTL and testbench

- Cycle-accurate, synthesizable model of one 101-stage selectable ring-oscillator delay chain (LVT, stress variant).
- One RTL module serves all three chain flavours (INV, NAND, NOR) via GATE_TYPE.
- Sits between the rosc stress controller, which drives IN and closes the loop with ~OUT, and the per-chain power controller, which supplies PWR_OK.
- Counts output transitions so accumulated stress activity can be read back.

---
 rtl/rosc101_sel_chain_lvt_stress_pkg.sv | 27 ++
 rtl/rosc101_sel_chain_lvt_stress_stage.sv | 32 +++
 rtl/rosc101_sel_chain_lvt_stress.sv | 88 ++++++++
 tb/tb_rosc101_sel_chain_lvt_stress.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rosc101_sel_chain_lvt_stress_pkg.sv
// Shared definitions for the selectable ring-oscillator delay chains:
// gate-type encodings, default chain length and the per-stage gate function.
package rosc_pkg;

   localparam int unsigned GATE_INV       = 0;
   localparam int unsigned GATE_NAND      = 1;
   localparam int unsigned GATE_NOR       = 2;
   localparam int unsigned STAGES_DEFAULT = 101;

   // Next value of one inverting stage given its input and the side input.
   // With side_en = 1 every gate type reduces to an inverter.
   function automatic logic gate_fn(input int unsigned gate_type,
                                    input logic        x,
                                    input logic        side_en);
      case (gate_type)
         GATE_NAND: return ~(x & side_en);
         GATE_NOR:  return ~(x | ~side_en);
         default:   return ~x;
      endcase
   endfunction

   // Settled chain pattern for IN = 0: 1 on even stages, 0 on odd stages.
   function automatic logic settled_val(input int unsigned idx);
      return (idx % 2) == 0;
   endfunction

endpackage

// File: rtl/rosc101_sel_chain_lvt_stress_stage.sv
// One chain stage: a single flop behind an INV/NAND2/NOR2 gate.
// Reset and power loss both load the stage's settled value.
module rosc_stage
   import rosc_pkg::*;
#(
   parameter int unsigned GATE_TYPE = GATE_INV,
   parameter logic        RST_VAL   = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwr_ok,
   input  logic x,
   input  logic side_en,
   output logic nxt,
   output logic s
);

   // Gate output for the current input; also used by the top's edge counter
   always_comb begin
      nxt = gate_fn(GATE_TYPE, x, side_en);
   end

   // Stage flop: parked at the settled value while in reset or unpowered
   always_ff @(posedge clk) begin
      if (!rst_n || !pwr_ok) begin
         s <= RST_VAL;
      end else begin
         s <= nxt;
      end
   end

endmodule

// File: rtl/rosc101_sel_chain_lvt_stress.sv
// 101-stage selectable ring-oscillator delay chain (LVT, stress variant).
// One clock models one gate delay; OUT is IN delayed by STAGES clocks.
// Counts transitions of the last stage for stress-activity readback.
// Optional mid-chain tap port enabled by defining ROSC_TAP_EN.
module rosc101_sel_chain_lvt_stress
   import rosc_pkg::*;
#(
   parameter int unsigned STAGES    = STAGES_DEFAULT,
   parameter int unsigned GATE_TYPE = GATE_INV,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN,
   input  logic             SIDE_EN,
   input  logic             PWR_OK,
   input  logic             CNT_CLR,
   output logic             OUT,
   output logic [CNT_W-1:0] TOGGLE_CNT
`ifdef ROSC_TAP_EN
   ,
   input  logic [7:0]       TAP_SEL,
   output logic [0:0]       TAP
`endif
);

   localparam logic             ODD     = (STAGES % 2) != 0;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [STAGES-1:0] s;
   logic [STAGES-1:0] nxt;
   logic [STAGES-1:0] chain_in;

   if (STAGES < 2) begin : g_bad_stages
      $error("rosc101_sel_chain_lvt_stress: STAGES must be at least 2");
   end
   if (GATE_TYPE > GATE_NOR) begin : g_bad_gate
      $error("rosc101_sel_chain_lvt_stress: GATE_TYPE must be 0, 1 or 2");
   end

   // Each stage is driven by its predecessor, the first one by IN
   always_comb begin
      chain_in = {s[STAGES-2:0], IN};
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      rosc_stage #(
         .GATE_TYPE (GATE_TYPE),
         .RST_VAL   (settled_val(i))
      ) u_stage (
         .clk     (CLK),
         .rst_n   (RST_N),
         .pwr_ok  (PWR_OK),
         .x       (chain_in[i]),
         .side_en (SIDE_EN),
         .nxt     (nxt[i]),
         .s       (s[i])
      );
   end

   // Undo the odd inversion count so OUT follows IN with the same polarity
   always_comb begin
      OUT = s[STAGES-1] ^ ODD;
   end

   // Saturating transition counter; clear wins over a same-cycle edge
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         TOGGLE_CNT <= '0;
      end else if (CNT_CLR) begin
         TOGGLE_CNT <= '0;
      end else if (PWR_OK && (nxt[STAGES-1] != s[STAGES-1]) &&
                   (TOGGLE_CNT != CNT_MAX)) begin
         TOGGLE_CNT <= TOGGLE_CNT + CNT_W'(1);
      end
   end

`ifdef ROSC_TAP_EN
   logic [255:0] tap_vec;

   // Zero-padded chain view, so selects beyond the last stage read 0
   always_comb begin
      tap_vec = 256'(s);
      TAP     = tap_vec[TAP_SEL];
   end
`endif

endmodule

// File: tb/tb_rosc101_sel_chain_lvt_stress.sv
// Directed self-checking bench for rosc101_sel_chain_lvt_stress.
// Four instances: INV, NAND, NOR (all 101 stages) and INV with a 4-bit counter.
module tb_rosc101_sel_chain_lvt_stress;
   import rosc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [3:0]  in_v;
   logic [3:0]  side_v;
   logic [3:0]  pwr_v;
   logic [3:0]  clr_v;
   logic        out_inv, out_nand, out_nor, out_sat;
   logic [31:0] cnt_inv, cnt_nand, cnt_nor;
   logic [3:0]  cnt_sat;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   rosc101_sel_chain_lvt_stress #(.GATE_TYPE(GATE_INV)) u_inv (
      .CLK(clk), .RST_N(rst_n), .IN(in_v[0]), .SIDE_EN(side_v[0]), .PWR_OK(pwr_v[0]),
      .CNT_CLR(clr_v[0]), .OUT(out_inv), .TOGGLE_CNT(cnt_inv)
   );
   rosc101_sel_chain_lvt_stress #(.GATE_TYPE(GATE_NAND)) u_nand (
      .CLK(clk), .RST_N(rst_n), .IN(in_v[1]), .SIDE_EN(side_v[1]), .PWR_OK(pwr_v[1]),
      .CNT_CLR(clr_v[1]), .OUT(out_nand), .TOGGLE_CNT(cnt_nand)
   );
   rosc101_sel_chain_lvt_stress #(.GATE_TYPE(GATE_NOR)) u_nor (
      .CLK(clk), .RST_N(rst_n), .IN(in_v[2]), .SIDE_EN(side_v[2]), .PWR_OK(pwr_v[2]),
      .CNT_CLR(clr_v[2]), .OUT(out_nor), .TOGGLE_CNT(cnt_nor)
   );
   rosc101_sel_chain_lvt_stress #(.GATE_TYPE(GATE_INV), .CNT_W(4)) u_sat (
      .CLK(clk), .RST_N(rst_n), .IN(in_v[3]), .SIDE_EN(side_v[3]), .PWR_OK(pwr_v[3]),
      .CNT_CLR(clr_v[3]), .OUT(out_sat), .TOGGLE_CNT(cnt_sat)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic out_of(input int unsigned w);
      case (w)
         0:       return out_inv;
         1:       return out_nand;
         2:       return out_nor;
         default: return out_sat;
      endcase
   endfunction

   // One-clock IN pulse on instance w, then count OUT-high cycles and the first one
   task automatic pulse_watch(input int unsigned w, input int unsigned span,
                              output int unsigned ones, output int unsigned first_at);
      ones     = 0;
      first_at = 0;
      in_v[w]  = 1'b1;
      tick();
      in_v[w]  = 1'b0;
      for (int unsigned j = 1; j <= span; j++) begin
         tick();
         if (out_of(w)) begin
            if (ones == 0) first_at = j;
            ones++;
         end
      end
   endtask

   // Pulse, let it travel half the chain, then remove the side input and watch
   task automatic park_test(input int unsigned w, input logic exp_out, output int unsigned bad,
                            output logic first_out);
      bad     = 0;
      in_v[w] = 1'b1;
      tick();
      in_v[w] = 1'b0;
      repeat (50) tick();
      side_v[w] = 1'b0;
      tick();
      first_out = out_of(w);
      for (int unsigned j = 0; j < 150; j++) begin
         in_v[w] = ~in_v[w];
         tick();
         if (out_of(w) !== exp_out) bad++;
      end
      in_v[w] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned ones, first_at, toggles, last_edge, bad_period, bad;
      logic        nv, prev, first_out;

      rst_n  = 1'b0;
      in_v   = '0;
      side_v = '1;
      pwr_v  = '1;
      clr_v  = '0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_out_inv", 32'(out_inv), 32'd0);
      check("rst_cnt_inv", cnt_inv, 32'd0);
      check("rst_out_nor", 32'(out_nor), 32'd0);
      check("rst_cnt_sat", 32'(cnt_sat), 32'd0);

      // Latency: a one-cycle pulse reappears exactly 101 clocks later
      pulse_watch(0, 150, ones, first_at);
      check("lat_ones", ones, 32'd1);
      check("lat_pos", first_at, 32'd100);
      check("lat_cnt", cnt_inv, 32'd2);

      // Loop oscillation through one external register
      clr_v[0] = 1'b1;
      tick();
      clr_v[0] = 1'b0;
      check("loop_clr", cnt_inv, 32'd0);
      prev = out_inv;
      toggles = 0;
      last_edge = 0;
      bad_period = 0;
      for (int unsigned c = 1; c <= 2040; c++) begin
         nv = ~out_inv;
         tick();
         in_v[0] = nv;
         if (out_inv !== prev) begin
            toggles++;
            if (last_edge != 0 && (c - last_edge) != 102) bad_period++;
            last_edge = c;
            prev = out_inv;
         end
      end
      check("loop_period_err", bad_period, 32'd0);
      check("loop_toggles", toggles, 32'd20);
      check("loop_cnt", cnt_inv, 32'd20);
      in_v[0] = 1'b0;
      repeat (210) tick();

      // Power loss while an edge is mid-chain
      clr_v[0] = 1'b1;
      tick();
      clr_v[0] = 1'b0;
      pulse_watch(0, 150, ones, first_at);
      check("pwr_pre_cnt", cnt_inv, 32'd2);
      bad = 0;
      in_v[0] = 1'b1;
      tick();
      in_v[0] = 1'b0;
      repeat (50) tick();
      pwr_v[0] = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         tick();
         if (out_inv !== 1'b0) bad++;
      end
      check("pwr_off_cnt_hold", cnt_inv, 32'd2);
      clr_v[0] = 1'b1;
      tick();
      clr_v[0] = 1'b0;
      if (out_inv !== 1'b0) bad++;
      check("pwr_off_clr", cnt_inv, 32'd0);
      pwr_v[0] = 1'b1;
      for (int unsigned k = 0; k < 150; k++) begin
         tick();
         if (out_inv !== 1'b0) bad++;
      end
      check("pwr_out_low", bad, 32'd0);
      check("pwr_post_cnt", cnt_inv, 32'd0);

      // NAND: inverter behaviour with side input, then park at all-ones
      pulse_watch(1, 150, ones, first_at);
      check("nand_lat_pos", first_at, 32'd100);
      check("nand_lat_cnt", cnt_nand, 32'd2);
      park_test(1, 1'b0, bad, first_out);
      check("nand_park_first", 32'(first_out), 32'd0);
      check("nand_park_steady", bad, 32'd0);
      check("nand_park_cnt", cnt_nand, 32'd2);

      // NOR: park at all-zeros, last stage falls once so the count steps once
      pulse_watch(2, 150, ones, first_at);
      check("nor_lat_pos", first_at, 32'd100);
      check("nor_lat_cnt", cnt_nor, 32'd2);
      park_test(2, 1'b1, bad, first_out);
      check("nor_park_first", 32'(first_out), 32'd1);
      check("nor_park_steady", bad, 32'd0);
      check("nor_park_cnt", cnt_nor, 32'd3);

      // 4-bit counter: 20 transitions saturate at 15
      for (int unsigned k = 0; k < 20; k++) begin
         in_v[3] = (k % 2) == 0;
         tick();
      end
      in_v[3] = 1'b0;
      repeat (130) tick();
      check("sat_cnt", 32'(cnt_sat), 32'd15);

      // Clear on the same edge as a last-stage transition
      in_v[3] = 1'b1;
      tick();
      in_v[3] = 1'b0;
      repeat (99) tick();
      clr_v[3] = 1'b1;
      tick();
      clr_v[3] = 1'b0;
      check("sat_clr_cnt", 32'(cnt_sat), 32'd0);
      check("sat_clr_out", 32'(out_sat), 32'd1);
      tick();
      check("sat_after_cnt", 32'(cnt_sat), 32'd1);
      check("sat_after_out", 32'(out_sat), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
